// File: rtl/decomp_fetch_ctrl.sv
// decomp_fetch_ctrl: walks a compressed instruction stream, expands table
// tokens (optionally repeated) and hands instructions to the core over a
// valid/ready port.
// Optional build macro DECOMP_STATS_EN adds token/raw-word counters.
module decomp_fetch_ctrl #(
  parameter int ADDR_W = 9,
  parameter int TBL_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [TBL_AW-1:0] tbl_idx,
  input  logic [35:0]       tbl_data,
  output logic [31:0]       instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy,
  output logic              tok_err
`ifdef DECOMP_STATS_EN
  ,
  output logic [15:0]       stat_tokens,
  output logic [15:0]       stat_raw
`endif
);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOOKUP, EMIT} state_t;

  state_t            state, nxt;
  logic [ADDR_W-1:0] addr_q, end_q;
  logic [3:0]        rpt_q;

  // Word classification while the fetched word is on mem_rdata
  logic       is_tok, tok_ok, rpt_last, xfer, at_end;
  logic [3:0] tok_off;

  assign is_tok   = (mem_rdata < 32'h10);
  assign tok_ok   = is_tok && (mem_rdata[3:0] >= 4'hA);
  assign tok_off  = mem_rdata[3:0] - 4'hA;
  assign rpt_last = (rpt_q <= 4'd1);
  assign xfer     = (state == EMIT) && instr_ready;
  assign at_end   = (addr_q == end_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic; start always wins so a busy start acts as an abort
  always_comb begin
    nxt = state;
    if (start) nxt = FETCH;
    else begin
      case (state)
        FETCH:   nxt = WAIT;
        WAIT:    nxt = tok_ok ? LOOKUP : EMIT;
        LOOKUP:  nxt = EMIT;
        EMIT:    if (xfer && rpt_last) nxt = at_end ? IDLE : FETCH;
        default: nxt = state;
      endcase
    end
  end

  // Outputs decoded from state; addresses are zero outside their phase
  always_comb begin
    mem_addr    = '0;
    tbl_idx     = '0;
    instr_valid = (state == EMIT);
    busy        = (state != IDLE);
    if (state == FETCH)          mem_addr = addr_q;
    if (state == WAIT && tok_ok) tbl_idx  = TBL_AW'(tok_off);
  end

  // Datapath: address walk, instruction latch, repeat count, error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      end_q   <= '0;
      instr   <= '0;
      rpt_q   <= '0;
      tok_err <= 1'b0;
    end else begin
      tok_err <= 1'b0;
      if (start) begin
        addr_q <= start_addr;
        end_q  <= end_addr;
        rpt_q  <= '0;
      end else begin
        case (state)
          WAIT: begin
            if (!is_tok) begin
              instr <= mem_rdata;
              rpt_q <= 4'd1;
            end else if (!tok_ok) begin
              // Unknown token: flag it and emit a single zero word
              instr   <= '0;
              rpt_q   <= 4'd1;
              tok_err <= 1'b1;
            end
          end
          LOOKUP: begin
            instr <= tbl_data[31:0];
            rpt_q <= (tbl_data[35:32] == 4'd0) ? 4'd2 : tbl_data[35:32];
          end
          EMIT: begin
            if (instr_ready) begin
              rpt_q <= rpt_q - 4'd1;
              // Natural ADDR_W overflow gives the wrap past the top word
              if (rpt_last && !at_end) addr_q <= addr_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef DECOMP_STATS_EN
  // Saturating counts of classified words, cleared by each start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_tokens <= '0;
      stat_raw    <= '0;
    end else if (start) begin
      stat_tokens <= '0;
      stat_raw    <= '0;
    end else if (state == WAIT) begin
      if (is_tok) begin
        if (stat_tokens != 16'hFFFF) stat_tokens <= stat_tokens + 16'd1;
      end else begin
        if (stat_raw != 16'hFFFF) stat_raw <= stat_raw + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_decomp_fetch_ctrl.sv
// Bench for decomp_fetch_ctrl: cycle tables per scenario plus a hand-written
// reset-in-LOOKUP sequence.
module tb_decomp_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  start_addr = '0;
  logic [8:0]  end_addr = '0;
  logic [8:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [3:0]  tbl_idx;
  logic [35:0] tbl_data = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        busy;
  logic        tok_err;
`ifdef DECOMP_STATS_EN
  logic [15:0] stat_tokens, stat_raw;
`endif

  decomp_fetch_ctrl #(.ADDR_W(9), .TBL_AW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .end_addr(end_addr), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .tbl_idx(tbl_idx), .tbl_data(tbl_data), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .busy(busy),
    .tok_err(tok_err)
`ifdef DECOMP_STATS_EN
    , .stat_tokens(stat_tokens), .stat_raw(stat_raw)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous-read memory and table models
  logic [31:0] mem [512];
  logic [35:0] tbl [16];
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr];
    tbl_data  <= tbl[tbl_idx];
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          seg;
    logic        st;
    logic [8:0]  sa, ea;
    logic        rdy;
    logic        ev;
    logic [31:0] ei;
    logic        eb, et;
    logic [8:0]  ema;
  } vec_t;

  vec_t vt[$];

  task automatic add(input int seg, input logic st, input logic [8:0] sa,
                     input logic [8:0] ea, input logic rdy, input logic ev,
                     input logic [31:0] ei, input logic eb, input logic et,
                     input logic [8:0] ema);
    vec_t v;
    v.seg = seg; v.st = st; v.sa = sa; v.ea = ea; v.rdy = rdy;
    v.ev = ev; v.ei = ei; v.eb = eb; v.et = et; v.ema = ema;
    vt.push_back(v);
  endtask

  task automatic load_mem(input int seg);
    case (seg)
      1: begin mem[0] = 32'h00A00093; mem[1] = 32'h00100113; end
      2: begin mem[0] = 32'h0000000A; tbl[0] = {4'h0, 32'h00208233}; end
      3: begin mem[0] = 32'h0000000B; tbl[1] = {4'h3, 32'h12345678}; end
      4: begin mem[0] = 32'h00000005; mem[1] = 32'h00100113; end
      5: begin mem[0] = 32'h00A00093; mem[7] = 32'h00700393; end
      6: begin mem[511] = 32'hDEADBEEF; mem[0] = 32'hCAFE0013; end
      default: ;
    endcase
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    for (int i = 0; i < 16; i++)  tbl[i] = '0;

    // seg sta sa ea rdy | valid instr busy tok_err mem_addr  (one row per cycle)
    // 1: two raw words, first valid on cycle 3, then IDLE
    add(1,1,0,1,1, 0,0,0,0,0);
    add(1,0,0,1,1, 0,0,1,0,0);
    add(1,0,0,1,1, 0,0,1,0,0);
    add(1,0,0,1,1, 1,32'h00A00093,1,0,0);
    add(1,0,0,1,1, 0,0,1,0,1);
    add(1,0,0,1,1, 0,0,1,0,0);
    add(1,0,0,1,1, 1,32'h00100113,1,0,0);
    add(1,0,0,1,1, 0,0,0,0,0);
    // 2: token A, repeat 0 -> twice, first valid on cycle 4
    add(2,1,0,0,1, 0,0,0,0,0);
    add(2,0,0,0,1, 0,0,1,0,0);
    add(2,0,0,0,1, 0,0,1,0,0);
    add(2,0,0,0,1, 0,0,1,0,0);
    add(2,0,0,0,1, 1,32'h00208233,1,0,0);
    add(2,0,0,0,1, 1,32'h00208233,1,0,0);
    add(2,0,0,0,1, 0,0,0,0,0);
    // 3: token B, repeat 3, ready low 5 cycles
    add(3,1,0,0,0, 0,0,0,0,0);
    add(3,0,0,0,0, 0,0,1,0,0);
    add(3,0,0,0,0, 0,0,1,0,0);
    add(3,0,0,0,0, 0,0,1,0,0);
    for (int k = 0; k < 5; k++) add(3,0,0,0,0, 1,32'h12345678,1,0,0);
    for (int k = 0; k < 3; k++) add(3,0,0,0,1, 1,32'h12345678,1,0,0);
    add(3,0,0,0,1, 0,0,0,0,0);
    // 4: invalid token 5 -> tok_err, zero word, stream continues
    add(4,1,0,1,1, 0,0,0,0,0);
    add(4,0,0,1,1, 0,0,1,0,0);
    add(4,0,0,1,1, 0,0,1,0,0);
    add(4,0,0,1,1, 1,32'h00000000,1,1,0);
    add(4,0,0,1,1, 0,0,1,0,1);
    add(4,0,0,1,1, 0,0,1,0,0);
    add(4,0,0,1,1, 1,32'h00100113,1,0,0);
    add(4,0,0,1,1, 0,0,0,0,0);
    // 5: restart at 7 while in EMIT
    add(5,1,0,5,0, 0,0,0,0,0);
    add(5,0,0,5,0, 0,0,1,0,0);
    add(5,0,0,5,0, 0,0,1,0,0);
    add(5,1,7,7,0, 1,32'h00A00093,1,0,0);
    add(5,0,7,7,1, 0,0,1,0,7);
    add(5,0,7,7,1, 0,0,1,0,0);
    add(5,0,7,7,1, 1,32'h00700393,1,0,0);
    add(5,0,7,7,1, 0,0,0,0,0);
    // 6: address wraps 511 -> 0
    add(6,1,511,0,1, 0,0,0,0,0);
    add(6,0,511,0,1, 0,0,1,0,511);
    add(6,0,511,0,1, 0,0,1,0,0);
    add(6,0,511,0,1, 1,32'hDEADBEEF,1,0,0);
    add(6,0,511,0,1, 0,0,1,0,0);
    add(6,0,511,0,1, 0,0,1,0,0);
    add(6,0,511,0,1, 1,32'hCAFE0013,1,0,0);
    add(6,0,511,0,1, 0,0,0,0,0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid", 32'(instr_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst tok_err", 32'(tok_err), 0);
    chk("rst instr", instr, 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst tbl_idx", 32'(tbl_idx), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < vt.size(); i++) begin
      if (i == 0 || vt[i].seg != vt[i-1].seg) load_mem(vt[i].seg);
      chk($sformatf("s%0d r%0d valid", vt[i].seg, i), 32'(instr_valid), 32'(vt[i].ev));
      chk($sformatf("s%0d r%0d busy", vt[i].seg, i), 32'(busy), 32'(vt[i].eb));
      chk($sformatf("s%0d r%0d tok_err", vt[i].seg, i), 32'(tok_err), 32'(vt[i].et));
      chk($sformatf("s%0d r%0d mem_addr", vt[i].seg, i), 32'(mem_addr), 32'(vt[i].ema));
      if (vt[i].ev) chk($sformatf("s%0d r%0d instr", vt[i].seg, i), instr, vt[i].ei);
      start       = vt[i].st;
      start_addr  = vt[i].sa;
      end_addr    = vt[i].ea;
      instr_ready = vt[i].rdy;
      tick();
    end
    start = 1'b0;

    // Reset asserted while in LOOKUP
    mem[0] = 32'h0000000B;
    start = 1'b1; start_addr = 0; end_addr = 0; instr_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("lk tbl_idx", 32'(tbl_idx), 1);
    tick();
    chk("lk busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst valid", 32'(instr_valid), 0);
    chk("arst busy", 32'(busy), 0);
    chk("arst tok_err", 32'(tok_err), 0);
    chk("arst instr", instr, 0);
    chk("arst mem_addr", 32'(mem_addr), 0);
    chk("arst tbl_idx", 32'(tbl_idx), 0);
`ifdef DECOMP_STATS_EN
    chk("arst stat_tokens", 32'(stat_tokens), 0);
    chk("arst stat_raw", 32'(stat_raw), 0);
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("start in rst busy", 32'(busy), 0);
    start = 1'b0;
    rst = 1'b0;
    tick();
    chk("post rst busy", 32'(busy), 0);
    chk("post rst valid", 32'(instr_valid), 0);

    // Clean stream after reset
    mem[0] = 32'h00A00093;
    start = 1'b1; start_addr = 0; end_addr = 0;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("restream valid", 32'(instr_valid), 1);
    chk("restream instr", instr, 32'h00A00093);
    tick();
    chk("restream idle", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
